// File: rtl/agu_issue_arbiter_pkg.sv
// Shared backend types for the AGU issue path: access sizes and the packet
// handed from the AGU output register to the LSU.
package agu_issue_arbiter_pkg;

  localparam int DEFAULT_TAG_W = 6;
  localparam int TAG_MAX_W     = 16;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2,
    MEM_RSVD = 2'd3
  } mem_size_t;

  // tag is sized for the widest ROB in use; narrower tags are zero-extended
  typedef struct packed {
    logic [31:0]          addr;
    logic                 is_store;
    mem_size_t            size;
    logic [TAG_MAX_W-1:0] tag;
    logic [31:0]          data;
    logic                 misaligned;
  } agu_lsu_pkt_t;

endpackage

// File: rtl/agu_addr_calc.sv
// Effective address (base + offset, modular) and natural-alignment check.
// Purely combinational; no handshake.
module agu_addr_calc
  import agu_issue_arbiter_pkg::*;
(
  input  logic [31:0] base,
  input  logic [31:0] offset,
  input  mem_size_t   size,
  output logic [31:0] addr,
  output logic        misaligned
);

  always_comb begin
    addr       = base + offset;
    misaligned = 1'b0;
    unique case (size)
      MEM_BYTE: misaligned = 1'b0;
      MEM_HALF: misaligned = addr[0];
      MEM_WORD: misaligned = (addr[1:0] != 2'b00);
      MEM_RSVD: misaligned = 1'b1;
      default:  misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/agu_issue_arbiter.sv
// Load/store issue arbiter over one AGU; accepted op is on lsu_* one cycle later.
// Accepts only when the output register is empty or draining; loads win unless a store has starved.
module agu_issue_arbiter
  import agu_issue_arbiter_pkg::*;
#(
  parameter int TAG_W            = DEFAULT_TAG_W,
  parameter int STORE_STARVE_MAX = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [31:0]      ld_base,
  input  logic [31:0]      ld_offset,
  input  logic [1:0]       ld_size,
  input  logic [TAG_W-1:0] ld_tag,
  input  logic             st_valid,
  output logic             st_ready,
  input  logic [31:0]      st_base,
  input  logic [31:0]      st_offset,
  input  logic [1:0]       st_size,
  input  logic [TAG_W-1:0] st_tag,
  input  logic [31:0]      st_data,
  output logic             lsu_valid,
  input  logic             lsu_ready,
  output logic [31:0]      lsu_addr,
  output logic             lsu_is_store,
  output logic [1:0]       lsu_size,
  output logic [TAG_W-1:0] lsu_tag,
  output logic [31:0]      lsu_data,
  output logic             lsu_misaligned
);

  localparam logic [3:0] STARVE_LIM = 4'(STORE_STARVE_MAX);

  logic         can_accept;
  logic         force_st;
  logic         grant_ld;
  logic         grant_st;
  logic         accept;
  logic [31:0]  sel_base;
  logic [31:0]  sel_offset;
  mem_size_t    sel_size;
  logic [31:0]  calc_addr;
  logic         calc_mis;
  logic [3:0]   starve_cnt_d, starve_cnt_q;
  logic         lsu_vld_d, lsu_vld_q;
  agu_lsu_pkt_t pkt_d, pkt_q;
  logic         unused_tag_bits;

  // Grants are decided from valids and the counter only, never from operand data
  always_comb begin
    can_accept = !lsu_vld_q || lsu_ready;
    force_st   = st_valid && (starve_cnt_q == STARVE_LIM);
    grant_st   = st_valid && (force_st || !ld_valid);
    grant_ld   = ld_valid && !force_st;
    ld_ready   = rst && can_accept && grant_ld && !flush;
    st_ready   = rst && can_accept && grant_st && !flush;
    accept     = ld_ready || st_ready;
    sel_base   = grant_st ? st_base : ld_base;
    sel_offset = grant_st ? st_offset : ld_offset;
    sel_size   = mem_size_t'(grant_st ? st_size : ld_size);
  end

  agu_addr_calc u_addr_calc (
    .base       (sel_base),
    .offset     (sel_offset),
    .size       (sel_size),
    .addr       (calc_addr),
    .misaligned (calc_mis)
  );

  // Backpressure (can_accept low) is not a denial, so the count holds there
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (flush || st_ready) begin
      starve_cnt_d = '0;
    end else if (st_valid && can_accept && (starve_cnt_q < STARVE_LIM)) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  always_comb begin
    lsu_vld_d = lsu_vld_q;
    pkt_d     = pkt_q;
    if (flush) begin
      lsu_vld_d = 1'b0;
    end else if (accept) begin
      lsu_vld_d        = 1'b1;
      pkt_d.addr       = calc_addr;
      pkt_d.is_store   = grant_st;
      pkt_d.size       = sel_size;
      pkt_d.tag        = TAG_MAX_W'(grant_st ? st_tag : ld_tag);
      pkt_d.data       = grant_st ? st_data : 32'd0;
      pkt_d.misaligned = calc_mis;
    end else if (lsu_ready) begin
      lsu_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      starve_cnt_q <= '0;
      lsu_vld_q    <= 1'b0;
      pkt_q        <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      lsu_vld_q    <= lsu_vld_d;
      pkt_q        <= pkt_d;
    end
  end

  assign lsu_valid       = lsu_vld_q;
  assign lsu_addr        = pkt_q.addr;
  assign lsu_is_store    = pkt_q.is_store;
  assign lsu_size        = pkt_q.size;
  assign lsu_tag         = pkt_q.tag[TAG_W-1:0];
  assign lsu_data        = pkt_q.data;
  assign lsu_misaligned  = pkt_q.misaligned;
  assign unused_tag_bits = ^pkt_q.tag;

endmodule

// File: tb/tb_agu_issue_arbiter.sv
// Bench for agu_issue_arbiter: address table, hand-written corner sequences
// and randomized traffic against a cycle-level reference model.
module tb_agu_issue_arbiter;

  localparam int TAG_W = 6;
  localparam int SMAX  = 4;

  logic             clk = 1'b0;
  logic             rst, flush;
  logic             ld_valid, ld_ready;
  logic [31:0]      ld_base, ld_offset;
  logic [1:0]       ld_size;
  logic [TAG_W-1:0] ld_tag;
  logic             st_valid, st_ready;
  logic [31:0]      st_base, st_offset, st_data;
  logic [1:0]       st_size;
  logic [TAG_W-1:0] st_tag;
  logic             lsu_valid, lsu_ready, lsu_is_store, lsu_misaligned;
  logic [31:0]      lsu_addr, lsu_data;
  logic [1:0]       lsu_size;
  logic [TAG_W-1:0] lsu_tag;

  agu_issue_arbiter #(.TAG_W(TAG_W), .STORE_STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_base(ld_base),
    .ld_offset(ld_offset), .ld_size(ld_size), .ld_tag(ld_tag),
    .st_valid(st_valid), .st_ready(st_ready), .st_base(st_base),
    .st_offset(st_offset), .st_size(st_size), .st_tag(st_tag), .st_data(st_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_addr(lsu_addr),
    .lsu_is_store(lsu_is_store), .lsu_size(lsu_size), .lsu_tag(lsu_tag),
    .lsu_data(lsu_data), .lsu_misaligned(lsu_misaligned)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    bit             v;
    bit [31:0]      addr;
    bit             st;
    bit [1:0]       size;
    bit [TAG_W-1:0] tag;
    bit [31:0]      data;
    bit             mis;
  } pkt_m_t;

  typedef struct {
    bit        is_st;
    bit [31:0] base;
    bit [31:0] off;
    bit [1:0]  size;
    bit [31:0] data;
    bit [31:0] exp_addr;
    bit        exp_mis;
  } vec_t;

  int     checks;
  int     errors;
  pkt_m_t m_out;
  int     m_starve;
  bit     last_ld_rdy, last_st_rdy;
  vec_t   vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit exp_mis(input bit [1:0] sz, input bit [31:0] a);
    case (sz)
      2'd0:    return 1'b0;
      2'd1:    return (a % 2) != 0;
      2'd2:    return (a % 4) != 0;
      default: return 1'b1;
    endcase
  endfunction

  // Store goes when it has waited SMAX denials or nobody else wants the slot
  task automatic model_grant(output bit gl, output bit gs);
    bit slot_free;
    bit st_turn;
    slot_free = !m_out.v || lsu_ready;
    st_turn   = st_valid && (m_starve == SMAX || !ld_valid);
    gl = 1'b0;
    gs = 1'b0;
    if (rst && !flush && slot_free) begin
      if (st_turn)       gs = 1'b1;
      else if (ld_valid) gl = 1'b1;
    end
  endtask

  task automatic tick();
    bit     gl, gs;
    pkt_m_t nxt;
    #3;
    model_grant(gl, gs);
    last_ld_rdy = ld_ready;
    last_st_rdy = st_ready;
    chk("ld_ready", 32'(ld_ready), 32'(gl));
    chk("st_ready", 32'(st_ready), 32'(gs));
    nxt = m_out;
    if (!rst) begin
      nxt      = '0;
      m_starve = 0;
    end else if (flush) begin
      nxt.v    = 1'b0;
      m_starve = 0;
    end else begin
      if (gl || gs) begin
        nxt.v    = 1'b1;
        nxt.st   = gs;
        nxt.addr = gs ? st_base + st_offset : ld_base + ld_offset;
        nxt.size = gs ? st_size : ld_size;
        nxt.tag  = gs ? st_tag : ld_tag;
        nxt.data = gs ? st_data : 32'd0;
        nxt.mis  = exp_mis(nxt.size, nxt.addr);
      end else if (lsu_ready) begin
        nxt.v = 1'b0;
      end
      if (gs) m_starve = 0;
      else if (st_valid && (!m_out.v || lsu_ready) && m_starve < SMAX) m_starve++;
    end
    @(posedge clk);
    #1;
    m_out = nxt;
    chk("lsu_valid", 32'(lsu_valid), 32'(m_out.v));
    chk("lsu_addr", lsu_addr, m_out.addr);
    chk("lsu_is_store", 32'(lsu_is_store), 32'(m_out.st));
    chk("lsu_size", 32'(lsu_size), 32'(m_out.size));
    chk("lsu_tag", 32'(lsu_tag), 32'(m_out.tag));
    chk("lsu_data", lsu_data, m_out.data);
    chk("lsu_misaligned", 32'(lsu_misaligned), 32'(m_out.mis));
  endtask

  task automatic set_idle();
    ld_valid = 1'b0; ld_base = '0; ld_offset = '0; ld_size = '0; ld_tag = '0;
    st_valid = 1'b0; st_base = '0; st_offset = '0; st_size = '0; st_tag = '0; st_data = '0;
  endtask

  task automatic set_ld(input bit [31:0] b, input bit [31:0] o, input bit [1:0] s, input bit [TAG_W-1:0] t);
    ld_valid = 1'b1; ld_base = b; ld_offset = o; ld_size = s; ld_tag = t;
  endtask

  task automatic set_st(input bit [31:0] b, input bit [31:0] o, input bit [1:0] s,
                        input bit [TAG_W-1:0] t, input bit [31:0] d);
    st_valid = 1'b1; st_base = b; st_offset = o; st_size = s; st_tag = t; st_data = d;
  endtask

  initial begin
    checks = 0; errors = 0; m_out = '0; m_starve = 0;
    rst = 1'b0; flush = 1'b0; lsu_ready = 1'b0;
    set_idle();

    vecs[0] = '{1'b0, 32'h0000_1000, 32'hFFFF_FFFC, 2'd2, 32'h0,         32'h0000_0FFC, 1'b0};
    vecs[1] = '{1'b1, 32'hFFFF_FFFF, 32'h0000_0002, 2'd1, 32'hDEAD_BEEF, 32'h0000_0001, 1'b1};
    vecs[2] = '{1'b1, 32'h0000_0000, 32'h0000_0000, 2'd3, 32'h1234_5678, 32'h0000_0000, 1'b1};
    vecs[3] = '{1'b0, 32'h0000_0003, 32'h0000_0000, 2'd0, 32'h0,         32'h0000_0003, 1'b0};
    vecs[4] = '{1'b0, 32'h0000_0010, 32'h0000_0002, 2'd1, 32'h0,         32'h0000_0012, 1'b0};
    vecs[5] = '{1'b0, 32'h0000_0010, 32'h0000_0002, 2'd2, 32'h0,         32'h0000_0012, 1'b1};
    vecs[6] = '{1'b1, 32'h7FFF_FFFC, 32'h0000_0004, 2'd2, 32'hA5A5_A5A5, 32'h8000_0000, 1'b0};
    vecs[7] = '{1'b0, 32'h0000_0000, 32'hFFFF_FFFF, 2'd1, 32'h0,         32'hFFFF_FFFF, 1'b1};

    tick();
    tick();
    chk("reset_lsu_valid", 32'(lsu_valid), 32'd0);
    chk("reset_ld_ready", 32'(last_ld_rdy), 32'd0);
    rst = 1'b1;

    // Single-op address/alignment table, each op drained before the next
    lsu_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      set_idle();
      if (vecs[i].is_st) set_st(vecs[i].base, vecs[i].off, vecs[i].size, TAG_W'(i), vecs[i].data);
      else               set_ld(vecs[i].base, vecs[i].off, vecs[i].size, TAG_W'(i));
      tick();
      chk("tbl_valid", 32'(lsu_valid), 32'd1);
      chk("tbl_addr", lsu_addr, vecs[i].exp_addr);
      chk("tbl_mis", 32'(lsu_misaligned), 32'(vecs[i].exp_mis));
      chk("tbl_is_store", 32'(lsu_is_store), 32'(vecs[i].is_st));
      chk("tbl_data", lsu_data, vecs[i].is_st ? vecs[i].data : 32'd0);
      set_idle();
      tick();
    end

    // Starvation: both ports busy, store forced every fifth cycle
    for (int i = 0; i < 10; i++) begin
      set_ld(32'h100 + 32'(i), 32'd0, 2'd0, TAG_W'(i));
      set_st(32'h200, 32'(i * 4), 2'd2, TAG_W'(i + 20), 32'(i));
      tick();
      chk("starve_pattern", 32'(last_st_rdy), 32'((i == 4) || (i == 9)));
    end

    // Backpressure: held op stays put, denials are not counted
    set_ld(32'h100, 32'h4, 2'd2, 6'd1);
    set_st(32'h300, 32'h0, 2'd2, 6'd2, 32'h55);
    tick();
    lsu_ready = 1'b0;
    set_ld(32'h200, 32'h0, 2'd2, 6'd3);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_ld_ready", 32'(last_ld_rdy), 32'd0);
      chk("bp_addr_hold", lsu_addr, 32'h104);
    end
    lsu_ready = 1'b1;
    tick();
    chk("bp_release_accept", 32'(last_ld_rdy), 32'd1);
    chk("bp_release_addr", lsu_addr, 32'h200);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_starve_resume", 32'(last_st_rdy), 32'(i == 2));
    end

    // Flush kills the held op and clears the denial count
    set_ld(32'h2000, 32'h10, 2'd2, 6'd4);
    tick();
    lsu_ready = 1'b0;
    tick();
    flush = 1'b1; lsu_ready = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_ld_ready", 32'(last_ld_rdy), 32'd0);
    chk("flush_st_ready", 32'(last_st_rdy), 32'd0);
    chk("flush_valid", 32'(lsu_valid), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("flush_starve_clear", 32'(last_st_rdy), 32'(i == 4));
    end

    // Reset mid-transfer drops the held op
    set_idle();
    set_ld(32'h3000, 32'h8, 2'd2, 6'd5);
    tick();
    lsu_ready = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk("rst_ld_ready", 32'(last_ld_rdy), 32'd0);
    chk("rst_valid", 32'(lsu_valid), 32'd0);
    chk("rst_addr", lsu_addr, 32'd0);
    lsu_ready = 1'b1;
    tick();
    chk("rst_hold_ld_ready", 32'(last_ld_rdy), 32'd0);
    rst = 1'b1;
    tick();
    chk("rst_release_ld_ready", 32'(last_ld_rdy), 32'd1);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      ld_valid  = 1'($urandom_range(0, 1));
      ld_base   = $urandom;
      ld_offset = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 64));
      ld_size   = 2'($urandom_range(0, 3));
      ld_tag    = TAG_W'($urandom);
      st_valid  = 1'($urandom_range(0, 1));
      st_base   = $urandom;
      st_offset = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 64));
      st_size   = 2'($urandom_range(0, 3));
      st_tag    = TAG_W'($urandom);
      st_data   = $urandom;
      lsu_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 29) == 0);
      rst       = !($urandom_range(0, 99) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
